// File: rtl/rr_wrr_arb.sv
// Weighted round-robin arbiter with multi-beat grant hold and fair rotation.
// Optional high-priority request class enabled by defining RR_WRR_PRIO_EN.
module rr_wrr_arb #(
   parameter int N  = 4,
   parameter int WW = 3,
   parameter int IW = $clog2(N)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic [N*WW-1:0] weight,
`ifdef RR_WRR_PRIO_EN
   input  logic [N-1:0]    hp_req,
`endif
   input  logic            ack,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [IW-1:0]   gnt_id,
   output logic            gnt_last
);

   logic [N-1:0]  gnt_q, gnt_d;
   logic          gnt_valid_q, gnt_valid_d;
   logic [IW-1:0] gnt_id_q, gnt_id_d;
   logic [WW-1:0] credit_q, credit_d;
   logic [IW-1:0] lp_q, lp_d;
   logic          hold, rel;
   logic [IW-1:0] lp_eff;
   logic [IW:0]   pick;
`ifdef RR_WRR_PRIO_EN
   logic [IW-1:0] hp_lp_q, hp_lp_d, hp_lp_eff;
   logic          own_hp_q, own_hp_d;
   logic [IW:0]   hp_pick, nm_pick;
`endif

   // First set bit of r after pointer p, wrapping, ending with p itself; MSB = found.
   function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
      logic [IW:0] res;
      int          idx;
      res = '0;
      for (int k = N; k >= 1; k--) begin
         idx = (int'(p) + k) % N;
         if (r[IW'(idx)]) res = {1'b1, IW'(idx)};
      end
      return res;
   endfunction

   function automatic logic [WW-1:0] load_credit(input logic [N*WW-1:0] w, input logic [IW-1:0] id);
      logic [WW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++)
         if (IW'(i) == id) c = w[i*WW +: WW];
      return (c == '0) ? WW'(1) : c;
   endfunction

   always_comb begin
      hold        = gnt_valid_q && req[gnt_id_q] && !(ack && credit_q == WW'(1));
      rel         = gnt_valid_q && !hold;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      credit_d    = credit_q;
      lp_d        = lp_q;
      lp_eff      = lp_q;
      pick        = '0;
`ifdef RR_WRR_PRIO_EN
      hp_lp_d     = hp_lp_q;
      hp_lp_eff   = hp_lp_q;
      own_hp_d    = own_hp_q;
      hp_pick     = '0;
      nm_pick     = '0;
`endif
      if (hold) begin
         if (ack && credit_q != '0) credit_d = credit_q - WW'(1);
      end else begin
`ifdef RR_WRR_PRIO_EN
         // The releasing owner moves only the pointer of the class it won from.
         if (rel && own_hp_q) begin
            hp_lp_d   = gnt_id_q;
            hp_lp_eff = gnt_id_q;
         end else if (rel) begin
            lp_d   = gnt_id_q;
            lp_eff = gnt_id_q;
         end
         hp_pick  = rr_pick(req & hp_req, hp_lp_eff);
         nm_pick  = rr_pick(req, lp_eff);
         pick     = hp_pick[IW] ? hp_pick : nm_pick;
         own_hp_d = hp_pick[IW];
`else
         if (rel) begin
            lp_d   = gnt_id_q;
            lp_eff = gnt_id_q;
         end
         pick = rr_pick(req, lp_eff);
`endif
         gnt_valid_d = pick[IW];
         gnt_id_d    = pick[IW] ? pick[IW-1:0] : '0;
         credit_d    = pick[IW] ? load_credit(weight, pick[IW-1:0]) : '0;
         for (int i = 0; i < N; i++)
            gnt_d[i] = pick[IW] && (IW'(i) == pick[IW-1:0]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         credit_q    <= '0;
         lp_q        <= IW'(N-1);
`ifdef RR_WRR_PRIO_EN
         hp_lp_q     <= IW'(N-1);
         own_hp_q    <= 1'b0;
`endif
      end else begin
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         credit_q    <= credit_d;
         lp_q        <= lp_d;
`ifdef RR_WRR_PRIO_EN
         hp_lp_q     <= hp_lp_d;
         own_hp_q    <= own_hp_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_last  = gnt_valid_q && (credit_q == WW'(1));

endmodule

// File: tb/tb_rr_wrr_arb.sv
// Bench for rr_wrr_arb: directed scenarios plus random traffic against a reference model.
module tb_rr_wrr_arb;
   localparam int N  = 4;
   localparam int WW = 3;
   localparam int IW = $clog2(N);

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*WW-1:0] weight;
   logic            ack;
   logic [N-1:0]    gnt;
   logic            gnt_valid;
   logic [IW-1:0]   gnt_id;
   logic            gnt_last;

   int total = 0;
   int bad   = 0;

   // Reference state: owner index (-1 idle), remaining beats, last owner.
   int m_owner, m_cred, m_lp;

   rr_wrr_arb #(.N(N), .WW(WW)) dut (
      .clock(clock), .reset(reset), .req(req), .weight(weight), .ack(ack),
      .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_last(gnt_last)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int w;
      if (reset) begin
         m_owner = -1; m_cred = 0; m_lp = N-1;
      end else if (m_owner >= 0 && req[m_owner] && !(ack && m_cred == 1)) begin
         if (ack && m_cred > 0) m_cred--;
      end else begin
         if (m_owner >= 0) m_lp = m_owner;
         m_owner = -1;
         for (int k = 1; k <= N; k++)
            if (m_owner < 0 && req[(m_lp + k) % N]) m_owner = (m_lp + k) % N;
         if (m_owner >= 0) begin
            w = int'(weight[m_owner*WW +: WW]);
            m_cred = (w == 0) ? 1 : w;
         end else m_cred = 0;
      end
   endtask

   task automatic step();
      logic [N-1:0] eg;
      model_edge();
      @(posedge clock);
      #1;
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
      chk("gnt_last", 32'(gnt_last), 32'(m_owner >= 0 && m_cred == 1));
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; ack = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] seq_a [5];
      logic [3:0] seq_b [8];
      logic [7:0] last_b;
      reset = 1'b1; req = '0; ack = 1'b0; weight = '0;
      m_owner = -1; m_cred = 0; m_lp = N-1;
      @(posedge clock); #1;

      // Reset state
      do_reset();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_last", 32'(gnt_last), 32'd0);

      // Plain rotation, weight 1, no idle cycle
      seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      weight = {3'd1, 3'd1, 3'd1, 3'd1}; req = 4'b1111; ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_seq", 32'(gnt), 32'(seq_a[i]));
      end

      // Weighted shares with gnt_last on each final beat
      do_reset();
      seq_b  = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
      last_b = 8'b1100_1101; // bit i = expected gnt_last in cycle i
      weight = {3'd3, 3'd1, 3'd2, 3'd1}; req = 4'b1111; ack = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("wrr_seq", 32'(gnt), 32'(seq_b[i]));
         chk("wrr_last", 32'(gnt_last), 32'(last_b[i]));
      end

      // Owner 1 drops request mid-grant
      do_reset();
      weight = {3'd1, 3'd1, 3'd3, 3'd1}; req = 4'b0010; ack = 1'b0;
      step();
      chk("drop_own", 32'(gnt), 32'b0010);
      ack = 1'b1; step();
      req = 4'b1101; ack = 1'b0; step();
      chk("drop_next", 32'(gnt), 32'b0100);

      // Sole requester keeps the grant and reloads credit
      do_reset();
      weight = {3'd1, 3'd2, 3'd1, 3'd1}; req = 4'b0100; ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("solo_gnt", 32'(gnt), 32'b0100);
         chk("solo_last", 32'(gnt_last), 32'(i % 2));
      end

      // Reset in the middle of a grant
      do_reset();
      req = 4'b0100; ack = 1'b0; step();
      reset = 1'b1; ack = 1'b1; step();
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_id", 32'(gnt_id), 32'd0);
      reset = 1'b0; req = 4'b1111; step();
      chk("midrst_first", 32'(gnt), 32'b0001);

      // Random traffic, including weight 0 and occasional reset
      for (int i = 0; i < 400; i++) begin
         reset  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         weight = (N*WW)'($urandom);
         ack    = ($urandom_range(0, 2) != 0);
         step();
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rr_wrr_arb.md
Name: rr_wrr_arb

Overview:
- Parameterised weighted round-robin arbiter with grant hold.
- Grants one of N requesters for up to weight[i] accepted beats (ack), then rotates fairly to the next requester.
- N is any integer >= 2, not restricted to a power of two.
- Sits between N initiators and one shared downstream resource. Replaces single-cycle round-robin arbitration where multi-beat ownership and per-requester bandwidth shares are needed.

Parameters:
- N, 4, number of requesters (>= 2, any integer).
- WW, 3, weight/credit width in bits; max beats per grant = 2**WW-1.
- IW, $clog2(N), width of the binary grant index (derived; not to be overridden).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N  per-requester request level; bit i = requester i.
- weight  input  N*WW  weight of requester i in bits [i*WW +: WW]; sampled only when i wins a grant.
- ack  input  1  downstream accepted one beat from the current owner this cycle.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_id  output  IW  registered binary index of the owner; 0 when idle.
- gnt_last  output  1  combinational; gnt_valid && credit==1, i.e. the next ack ends the grant.

Behaviour:
- State:
  - owner (gnt/gnt_id/gnt_valid).
  - credit counter, WW bits.
  - last-owner pointer lp, IW bits.
- Reset (synchronous, also mid-grant): next edge clears gnt=0, gnt_valid=0, gnt_id=0, credit=0, and sets lp=N-1 so requester 0 has first priority. Any pending ack in that cycle is ignored.
- Each cycle the next state is computed from the current state and inputs; all outputs except gnt_last update on the next edge. Latency from req rising to gnt is 1 cycle.
- HOLD: gnt_valid=1, req[gnt_id]=1, and not (ack && credit==1).
  - Owner is kept.
  - On ack, credit decrements by 1.
- RELEASE: gnt_valid=1 and (req[gnt_id]=0 or (ack && credit==1)).
  - lp is set to gnt_id.
  - Arbitration runs in the same cycle, so there is no idle bubble between owners.
- IDLE (gnt_valid=0): arbitration runs every cycle.
- Arbitration:
  - Winner is the first set bit of req searching indices lp+1, lp+2, ... wrapping modulo N, ending with lp itself.
  - The releasing owner wins again only if it is the sole requester. It then receives a fresh credit load.
  - No req asserted: gnt=0 next cycle and lp is unchanged.
- Credit load on win: credit = weight[winner], with weight 0 treated as 1.
- ack with gnt_valid=0 is ignored.
- ack in the same cycle the owner drops req still counts as a beat, but the release happens regardless.
- Requester behaviour is not checked: req may drop at any time. A drop causes release on the next edge and never corrupts the pointer.
- Credit never underflows; it is only decremented while credit >= 1.
- Fairness: any continuously asserting requester is granted within N-1 intervening grants.

Optional Feature:
- Macro RR_WRR_PRIO_EN.
- Defined:
  - Adds input hp_req (N bits) and a second pointer hp_lp (reset N-1).
  - At each arbitration point, candidates req & hp_req are searched first using hp_lp. If any exist, the winner updates hp_lp on its release.
  - Otherwise the normal class is searched using lp.
  - A current owner is never preempted.
- Undefined:
  - Port hp_req and pointer hp_lp are absent.
  - Single class, behaviour exactly as above.

Test Plan (N=4, WW=3):
- Reset then req=4'b1111, all weights 1, ack held 1 -> gnt sequence 0001, 0010, 0100, 1000, 0001, one per cycle, no idle cycle.
- weight={3,1,2,1} (req3..req0), req=1111, ack=1 -> owners in order 0×1, 1×2, 2×1, 3×3 cycles, then back to 0; gnt_last=1 on the final beat of each grant.
- Owner 1 with credit 3: drop req[1] after 1 ack, req=1101 -> next cycle gnt=0100 and lp=1.
- Single requester req=0100, weight 2, ack=1 -> gnt stays 0100 continuously; credit reloads to 2 every 2 beats.
- Assert reset mid-grant (owner 2, credit 2) -> next edge gnt=0 and gnt_id=0. After release with req=1111, first gnt=0001.
- RR_WRR_PRIO_EN defined: owner 0 active, hp_req=1000 and req=1111 -> gnt 0001 completes its credits, then 1000 is granted before 0010.
